// File: rtl/hs_ram_arbiter.sv
// Arbitrates a single-port RAM between the CPU and a hiscore engine. The hiscore side
// pauses the CPU via hold_req and only owns the RAM once cpu_halted is acknowledged.
module hs_ram_arbiter #(
  parameter int unsigned ACK_TIMEOUT  = 255,
  parameter int unsigned GUARD_CYCLES = 2
) (
  input  logic        clk_sys,
  input  logic        reset,

  input  logic        hs_access,
  input  logic [15:0] hs_address,
  input  logic [7:0]  hs_data_in,
  input  logic        hs_write,
  output logic [7:0]  hs_data_out,
  output logic        hs_ready,

  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_we,
  input  logic        cpu_halted,
  output logic        hold_req,

  output logic [15:0] ram_addr,
  output logic [7:0]  ram_din,
  output logic        ram_we,
  input  logic [7:0]  ram_dout,

  output logic        owner,
  output logic        timeout_err
);

  localparam int unsigned Guard = (GUARD_CYCLES < 1) ? 1 : GUARD_CYCLES;
  localparam logic [16:0] AckTimeout = 17'(ACK_TIMEOUT);
  localparam logic [15:0] GuardLast  = 16'(Guard - 1);

  typedef enum logic [1:0] {StIdle, StWait, StGrant, StRelease} state_e;

  state_e      state_q, state_d;
  logic [15:0] wait_cnt_q;
  logic [15:0] rel_cnt_q;
  logic        hold_req_q;
  logic        owner_q;
  logic        hs_ready_q;
  logic        timeout_err_q;
  logic        set_err;
  logic        wait_last;
  logic        rel_last;

  // wait_cnt_q counts completed WAIT cycles, so this cycle is the ACK_TIMEOUT-th one.
  assign wait_last = ({1'b0, wait_cnt_q} + 17'd1) >= AckTimeout;
  assign rel_last  = (rel_cnt_q == GuardLast);

  always_comb begin
    state_d = state_q;
    set_err = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (hs_access) state_d = StWait;
      end
      StWait: begin
        if (!hs_access) begin
          state_d = StIdle;
        end else if (cpu_halted) begin
          state_d = StGrant;
        end else if (wait_last) begin
          state_d = StRelease;
          set_err = 1'b1;
        end
      end
      StGrant: begin
        if (!hs_access) begin
          state_d = StRelease;
        end else if (!cpu_halted) begin
          state_d = StRelease;
          set_err = 1'b1;
        end
      end
      StRelease: begin
        if (rel_last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q       <= StIdle;
      wait_cnt_q    <= '0;
      rel_cnt_q     <= '0;
      hold_req_q    <= 1'b0;
      owner_q       <= 1'b0;
      hs_ready_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= (state_q == StWait && state_d == StWait) ? wait_cnt_q + 16'd1 : '0;
      rel_cnt_q  <= (state_q == StRelease && state_d == StRelease) ? rel_cnt_q + 16'd1 : '0;
      hold_req_q <= (state_d == StWait) || (state_d == StGrant);
      owner_q    <= (state_d == StGrant);
      // First GRANT cycle has no read data yet; only a continuing grant reports it.
      hs_ready_q <= (state_q == StGrant) && (state_d == StGrant);
      if (set_err) timeout_err_q <= 1'b1;
    end
  end

  always_comb begin
    ram_addr = cpu_addr;
    ram_din  = cpu_dout;
    ram_we   = cpu_we;
    if (owner_q) begin
      ram_addr = hs_address;
      ram_din  = hs_data_in;
      // A dropped halt aborts the grant; never write while the CPU may be back on the bus.
      ram_we   = hs_write & hs_access & cpu_halted;
    end
  end

  assign hs_data_out = ram_dout;
  assign hs_ready    = hs_ready_q;
  assign hold_req    = hold_req_q;
  assign owner       = owner_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_hs_ram_arbiter.sv
// Directed bench for hs_ram_arbiter: read, write, abort, guard, withdrawal, timeout, reset.
module tb_hs_ram_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        hs_access;
  logic [15:0] hs_address;
  logic [7:0]  hs_data_in;
  logic        hs_write;
  logic [7:0]  hs_data_out;
  logic        hs_ready;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_we;
  logic        cpu_halted;
  logic        hold_req;
  logic [15:0] ram_addr;
  logic [7:0]  ram_din;
  logic        ram_we;
  logic [7:0]  ram_dout;
  logic        owner;
  logic        timeout_err;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk_sys = ~clk_sys;

  hs_ram_arbiter #(
    .ACK_TIMEOUT (255),
    .GUARD_CYCLES(2)
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .hs_access  (hs_access),
    .hs_address (hs_address),
    .hs_data_in (hs_data_in),
    .hs_write   (hs_write),
    .hs_data_out(hs_data_out),
    .hs_ready   (hs_ready),
    .cpu_addr   (cpu_addr),
    .cpu_dout   (cpu_dout),
    .cpu_we     (cpu_we),
    .cpu_halted (cpu_halted),
    .hold_req   (hold_req),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_we     (ram_we),
    .ram_dout   (ram_dout),
    .owner      (owner),
    .timeout_err(timeout_err)
  );

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    hs_access  = 1'b0;
    hs_address = 16'h0000;
    hs_data_in = 8'h00;
    hs_write   = 1'b0;
    cpu_addr   = 16'h1234;
    cpu_dout   = 8'h55;
    cpu_we     = 1'b1;
    cpu_halted = 1'b0;
    ram_dout   = 8'h3C;
    tick();
    tick();
    reset = 1'b0;

    // Reset state: CPU owns the RAM
    chk("rst_owner", owner, 0);
    chk("rst_hold", hold_req, 0);
    chk("rst_ready", hs_ready, 0);
    chk("rst_err", timeout_err, 0);
    chk("rst_addr", ram_addr, 16'h1234);
    chk("rst_din", ram_din, 8'h55);
    chk("rst_we", ram_we, 1);
    chk("rst_dout", hs_data_out, 8'h3C);

    // Normal read, halt acknowledged 3 cycles after hold_req
    hs_access  = 1'b1;
    hs_address = 16'h6100;
    tick();
    chk("rd_hold", hold_req, 1);
    chk("rd_wait_owner", owner, 0);
    chk("rd_wait_addr", ram_addr, 16'h1234);
    tick();
    tick();
    cpu_halted = 1'b1;
    tick();
    chk("rd_owner", owner, 1);
    chk("rd_addr", ram_addr, 16'h6100);
    chk("rd_ready_first", hs_ready, 0);
    chk("rd_cpu_we_blocked", ram_we, 0);
    ram_dout = 8'hC7;
    #1;
    chk("rd_dout", hs_data_out, 8'hC7);
    tick();
    chk("rd_ready", hs_ready, 1);
    chk("rd_hold_grant", hold_req, 1);

    // Write in GRANT with concurrent cpu_we
    hs_write   = 1'b1;
    hs_data_in = 8'hA5;
    hs_address = 16'h6200;
    #1;
    chk("wr_we", ram_we, 1);
    chk("wr_din", ram_din, 8'hA5);
    chk("wr_addr", ram_addr, 16'h6200);
    tick();
    chk("wr_owner", owner, 1);

    // Halt drops mid-grant: write suppressed, abort with error
    cpu_halted = 1'b0;
    #1;
    chk("ab_we_suppressed", ram_we, 0);
    tick();
    hs_write = 1'b0;
    chk("ab_owner", owner, 0);
    chk("ab_hold", hold_req, 0);
    chk("ab_err", timeout_err, 1);
    chk("ab_ready", hs_ready, 0);
    chk("ab_cpu_addr", ram_addr, 16'h1234);
    chk("ab_cpu_we", ram_we, 1);

    // Guard: hs_access held, 2 RELEASE cycles + 1 IDLE before WAIT
    tick();
    chk("gd_rel2_hold", hold_req, 0);
    chk("gd_rel2_owner", owner, 0);
    tick();
    chk("gd_idle_hold", hold_req, 0);
    tick();
    chk("gd_wait_hold", hold_req, 1);
    chk("gd_err_sticky", timeout_err, 1);

    hs_access = 1'b0;
    reset     = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst2_err", timeout_err, 0);
    chk("rst2_hold", hold_req, 0);

    // Withdrawal after 5 WAIT cycles
    hs_access = 1'b1;
    tick();
    chk("wd_hold1", hold_req, 1);
    repeat (4) tick();
    chk("wd_hold5", hold_req, 1);
    hs_access = 1'b0;
    tick();
    chk("wd_hold", hold_req, 0);
    chk("wd_err", timeout_err, 0);
    chk("wd_owner", owner, 0);

    // Timeout: 255 WAIT cycles with no halt
    hs_access = 1'b1;
    tick();
    repeat (254) tick();
    chk("to_hold_pre", hold_req, 1);
    chk("to_err_pre", timeout_err, 0);
    tick();
    chk("to_hold", hold_req, 0);
    chk("to_err", timeout_err, 1);
    chk("to_ready", hs_ready, 0);
    chk("to_owner", owner, 0);

    // Halt arriving in the timeout cycle wins
    hs_access = 1'b0;
    reset     = 1'b1;
    tick();
    reset     = 1'b0;
    hs_access = 1'b1;
    tick();
    repeat (254) tick();
    cpu_halted = 1'b1;
    tick();
    chk("tie_owner", owner, 1);
    chk("tie_err", timeout_err, 0);
    chk("tie_hold", hold_req, 1);

    // Reset mid-GRANT restores the CPU path
    tick();
    chk("mg_ready", hs_ready, 1);
    cpu_addr = 16'hBEEF;
    cpu_we   = 1'b0;
    reset    = 1'b1;
    tick();
    reset = 1'b0;
    chk("mg_owner", owner, 0);
    chk("mg_hold", hold_req, 0);
    chk("mg_ready0", hs_ready, 0);
    chk("mg_addr", ram_addr, 16'hBEEF);
    chk("mg_we", ram_we, 0);
    hs_access = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hs_ram_arbiter.md
HS_RAM_ARBITER -- requirements
Module: hs_ram_arbiter

Interface
REQ-001 Parameter: ACK_TIMEOUT, default 255, is the maximum number of WAIT cycles allowed for the CPU halt acknowledge.
REQ-002 Parameter: GUARD_CYCLES, default 2, is the number of RELEASE cycles before a new request is accepted (minimum 1).
REQ-003 Port: clk_sys, in, 1, the single clock for all logic.
REQ-004 Port: reset, in, 1, synchronous active-high reset.
REQ-005 Port: hs_access, in, 1, the hiscore engine's request to own the RAM (a level signal).
REQ-006 Port: hs_address, in, 16, the hiscore RAM address.
REQ-007 Port: hs_data_in, in, 8, the hiscore write data.
REQ-008 Port: hs_write, in, 1, the hiscore write strobe.
REQ-009 Port: hs_data_out, out, 8, the RAM read data returned to the hiscore engine.
REQ-010 Port: hs_ready, out, 1, high when hs_data_out is valid for the address presented in the previous cycle.
REQ-011 Port: cpu_addr, in, 16, the CPU RAM address.
REQ-012 Port: cpu_dout, in, 8, the CPU write data.
REQ-013 Port: cpu_we, in, 1, the CPU write strobe.
REQ-014 Port: cpu_halted, in, 1, the CPU acknowledge that it is paused and off the bus.
REQ-015 Port: hold_req, out, 1, the pause request to the CPU.
REQ-016 Port: ram_addr, out, 16, the muxed RAM address.
REQ-017 Port: ram_din, out, 8, the muxed RAM write data.
REQ-018 Port: ram_we, out, 1, the muxed RAM write enable.
REQ-019 Port: ram_dout, in, 8, the synchronous RAM read data, valid 1 cycle after the address.
REQ-020 Port: owner, out, 1, RAM ownership (0 = CPU, 1 = hiscore).
REQ-021 Port: timeout_err, out, 1, a sticky error flag.

Function
REQ-022 The arbiter SHALL implement the states IDLE, WAIT, GRANT and RELEASE, held in registers.
REQ-023 In IDLE, hs_access=1 SHALL move the FSM to WAIT on the next edge; otherwise it SHALL stay in IDLE.
REQ-024 hold_req SHALL be registered and high exactly in WAIT and GRANT.
REQ-025 In WAIT, a 16-bit counter SHALL increment each cycle, starting from 0.
  - cpu_halted=1 and hs_access=1 -> GRANT.
  - hs_access=0 -> IDLE immediately, with no error.
  - counter reaching ACK_TIMEOUT with no halt -> RELEASE and timeout_err set.
  - cpu_halted and timeout in the same cycle -> the halt wins (GRANT).
REQ-026 owner SHALL be 1 only in GRANT; ram_addr, ram_din and ram_we SHALL combinationally select the hs_* signals when owner=1 and the cpu_* signals otherwise.
REQ-027 In GRANT, ram_we SHALL equal hs_write & hs_access; cpu_we SHALL never reach the RAM in GRANT.
REQ-028 hs_data_out SHALL equal ram_dout at all times.
REQ-029 hs_ready SHALL be a register set on the second and later GRANT cycles and cleared in every other state, so the first GRANT cycle never reports data.
REQ-030 In GRANT, hs_access=0 SHALL move the FSM to RELEASE.
REQ-031 In GRANT, cpu_halted falling while hs_access=1 SHALL abort to RELEASE and set timeout_err; ram_we SHALL be suppressed in that cycle.
REQ-032 RELEASE SHALL last exactly GUARD_CYCLES cycles with hold_req=0, then go to IDLE; hs_access is ignored during RELEASE.
REQ-033 timeout_err SHALL clear only on reset.
REQ-034 Back-to-back requests SHALL always be separated by at least GUARD_CYCLES+1 cycles of CPU ownership.

Reset
REQ-035 reset=1 SHALL force IDLE on the next edge from any state, including mid-GRANT.
REQ-036 Reset SHALL clear hold_req=0, hs_ready=0, timeout_err=0, and the WAIT and RELEASE counters.
REQ-037 After the reset edge, owner SHALL be 0, so the RAM returns to the CPU.

Verification
REQ-038 Normal read: hs_access=1, hs_address=0x6100, cpu_halted rising 3 cycles after hold_req -> owner=1, ram_addr=0x6100, hs_ready=1 one cycle later, hs_data_out=ram_dout.
REQ-039 Write: in GRANT, hs_write=1, hs_data_in=0xA5, hs_address=0x6200 -> ram_we=1, ram_din=0xA5, ram_addr=0x6200; a concurrent cpu_we=1 is blocked.
REQ-040 Timeout: cpu_halted held 0 -> RELEASE after 255 WAIT cycles, timeout_err=1, hold_req=0, hs_ready stays 0.
REQ-041 Withdrawal: hs_access dropped after 5 WAIT cycles -> IDLE next edge, hold_req=0, timeout_err=0.
REQ-042 Reset mid-GRANT: reset pulse while owner=1 -> owner=0, hold_req=0, hs_ready=0 after the edge; the CPU path is restored.
REQ-043 Guard: hs_access held 1 continuously -> after release, exactly 2 RELEASE cycles with owner=0 and hold_req=0 before WAIT is re-entered.
